// File: rtl/alu_pkg.sv
// Shared encodings for alu_mdu_unit: ALU select codes, alu_op/funct3 constants,
// FSM state type and the request decoder used at accept time.
package alu_pkg;

  typedef enum logic [3:0] {
    SEL_AND  = 4'd0,
    SEL_OR   = 4'd1,
    SEL_XOR  = 4'd2,
    SEL_ADD  = 4'd3,
    SEL_SUB  = 4'd4,
    SEL_SLT  = 4'd5,
    SEL_SLTU = 4'd6,
    SEL_SLLI = 4'd7,
    SEL_SRLI = 4'd8,
    SEL_SRAI = 4'd9,
    SEL_SLL  = 4'd10,
    SEL_SRL  = 4'd11,
    SEL_SRA  = 4'd12,
    SEL_MDU  = 4'd13
  } alu_sel_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_I   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  typedef struct packed {
    alu_sel_e sel;
    logic     illegal;
    logic     is_m;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] alu_op, input logic [2:0] f3,
                                  input logic f7_5, input logic f7_0, input logic mdu_en);
    dec_t d;
    d.sel     = SEL_AND;
    d.illegal = 1'b0;
    d.is_m    = 1'b0;
    case (alu_op)
      OP_ADD: d.sel = SEL_ADD;
      OP_SUB: d.sel = SEL_SUB;
      OP_R: begin
        if (f7_0) begin
          if (mdu_en && !f7_5) begin
            d.sel  = SEL_MDU;
            d.is_m = 1'b1;
          end else begin
            d.illegal = 1'b1;
          end
        end else begin
          case (f3)
            F3_ADD:  d.sel = f7_5 ? SEL_SUB : SEL_ADD;
            F3_SLL:  d.sel = SEL_SLL;
            F3_SLT:  d.sel = SEL_SLT;
            F3_SLTU: d.sel = SEL_SLTU;
            F3_XOR:  d.sel = SEL_XOR;
            F3_SR:   d.sel = f7_5 ? SEL_SRA : SEL_SRL;
            F3_OR:   d.sel = SEL_OR;
            F3_AND:  d.sel = SEL_AND;
          endcase
          // inst[30] only distinguishes sub and sra; anywhere else it is a bad encoding
          if (f7_5 && f3 != F3_ADD && f3 != F3_SR) d.illegal = 1'b1;
        end
      end
      default: begin
        case (f3)
          F3_ADD:  d.sel = SEL_ADD;
          F3_SLL:  d.sel = SEL_SLLI;
          F3_SLT:  d.sel = SEL_SLT;
          F3_SLTU: d.sel = SEL_SLTU;
          F3_XOR:  d.sel = SEL_XOR;
          F3_SR:   d.sel = f7_5 ? SEL_SRAI : SEL_SRLI;
          F3_OR:   d.sel = SEL_OR;
          F3_AND:  d.sel = SEL_AND;
        endcase
        if (f7_5 && f3 == F3_SLL) d.illegal = 1'b1;
      end
    endcase
    if (d.illegal) d.sel = SEL_AND;
    return d;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes, then a
// combinational sign fixup read by the parent in the final BUSY cycle.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, mb;
  logic            is_div, sel_hi, neg_q, neg_r, div0;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] ma_in, mb_in;

  // hi:lo is the product accumulator for multiplies and remainder:quotient for divides
  function automatic logic [2*XLEN-1:0] step(input logic [XLEN-1:0] h, input logic [XLEN-1:0] l,
                                             input logic [XLEN-1:0] m, input logic dv);
    logic [XLEN:0] sum;
    logic [XLEN:0] rp;
    if (!dv) begin
      sum = l[0] ? ({1'b0, h} + {1'b0, m}) : {1'b0, h};
      return {sum, l[XLEN-1:1]};
    end
    rp = {h, l[XLEN-1]};
    if (rp >= {1'b0, m}) return {XLEN'(rp - {1'b0, m}), l[XLEN-2:0], 1'b1};
    return {rp[XLEN-1:0], l[XLEN-2:0], 1'b0};
  endfunction

  always_comb begin
    a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg = a_sgn && op_a[XLEN-1];
    b_neg = b_sgn && op_b[XLEN-1];
    ma_in = a_neg ? -op_a : op_a;
    mb_in = b_neg ? -op_b : op_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      mb     <= '0;
      is_div <= 1'b0;
      sel_hi <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      // first bit is processed straight from the operands so the last iteration
      // lands one cycle before the fixup result is captured
      busy      <= 1'b1;
      cnt       <= CW'(1);
      {hi, lo}  <= step('0, ma_in, mb_in, funct3[2]);
      mb        <= mb_in;
      is_div    <= funct3[2];
      sel_hi    <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
      neg_q     <= a_neg ^ b_neg;
      neg_r     <= a_neg;
      div0      <= (op_b == '0);
    end else if (busy) begin
      if (cnt == CW'(XLEN)) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        {hi, lo} <= step(hi, lo, mb, is_div);
        cnt      <= cnt + 1'b1;
      end
    end
  end

  assign done = busy && (cnt == CW'(XLEN));

  always_comb begin
    if (!is_div) begin
      // high half of -{hi,lo}: carry into the top only when the low half is zero
      if (sel_hi) result = neg_q ? (~hi + {{(XLEN-1){1'b0}}, (lo == '0)}) : hi;
      else        result = lo;
    end else if (sel_hi) begin
      result = neg_r ? -hi : hi;
    end else if (div0) begin
      result = '1;
    end else begin
      result = neg_q ? -lo : lo;
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// ALU with optional iterative M-extension unit; define MDU_EN to build the
// mul/div datapath, otherwise M encodings decode as illegal and all ops take one cycle.
module alu_mdu_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_sel,
  output logic            illegal_op,
  output logic            valid_out,
  input  logic            ready_in
);

  localparam int SHW = $clog2(XLEN);
`ifdef MDU_EN
  localparam logic MDU_ON = 1'b1;
`else
  localparam logic MDU_ON = 1'b0;
`endif

  state_e          state;
  dec_t            dec;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  assign ready_out = (state == ST_IDLE);
  assign accept    = valid_in && ready_out && !flush;
  assign shamt     = op_b[SHW-1:0];

  always_comb dec = decode(alu_op, funct3, funct7_5, funct7_0, MDU_ON);

  always_comb begin
    alu_res = '0;
    case (dec.sel)
      SEL_AND:            alu_res = op_a & op_b;
      SEL_OR:             alu_res = op_a | op_b;
      SEL_XOR:            alu_res = op_a ^ op_b;
      SEL_ADD:            alu_res = op_a + op_b;
      SEL_SUB:            alu_res = op_a - op_b;
      SEL_SLT:            alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      SEL_SLTU:           alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      SEL_SLL, SEL_SLLI:  alu_res = op_a << shamt;
      SEL_SRL, SEL_SRLI:  alu_res = op_a >> shamt;
      SEL_SRA, SEL_SRAI:  alu_res = $unsigned($signed(op_a) >>> shamt);
      default:            alu_res = '0;
    endcase
  end

`ifdef MDU_EN
  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && dec.is_m),
    .abort  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .done   (mdu_done),
    .result (mdu_res)
  );
`else
  assign mdu_done = 1'b0;
  assign mdu_res  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      result     <= '0;
      alu_sel    <= '0;
      illegal_op <= 1'b0;
      valid_out  <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      valid_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            alu_sel    <= dec.sel;
            illegal_op <= dec.illegal;
            if (dec.is_m) begin
              state <= ST_BUSY;
            end else begin
              result    <= dec.illegal ? '0 : alu_res;
              valid_out <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (mdu_done) begin
            result    <= mdu_res;
            valid_out <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed vector bench for alu_mdu_unit (XLEN=32); M-op vectors are selected by MDU_EN.
module tb_alu_mdu_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_in, ready_out;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, funct7_0;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  alu_sel;
  logic        illegal_op, valid_out, ready_in;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        f70;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  sel;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_mdu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .op_a(op_a), .op_b(op_b), .result(result), .alu_sel(alu_sel),
    .illegal_op(illegal_op), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(string n, logic [1:0] op, logic [2:0] f3, logic f75, logic f70,
                              logic [31:0] a, logic [31:0] b, logic [31:0] res,
                              logic [3:0] sel, logic ill, int lat);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f75 = f75; v.f70 = f70;
    v.a = a; v.b = b; v.res = res; v.sel = sel; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                       input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op_a = a; op_b = b;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    drive(v.op, v.f3, v.f75, v.f70, v.a, v.b);
    lat = 1;
    while (!valid_out && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, {32'd0, result}, {32'd0, v.res});
    chk({v.name, " alu_sel"}, {60'd0, alu_sel}, {60'd0, v.sel});
    chk({v.name, " illegal"}, {63'd0, illegal_op}, {63'd0, v.ill});
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    chk({v.name, " release"}, {62'd0, ready_out, valid_out}, 64'b10);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (valid_out) seen = 1'b1;
    end
    chk(name, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    alu_op = '0; funct3 = '0; funct7_5 = 1'b0; funct7_0 = 1'b0; op_a = '0; op_b = '0;

    vecs.push_back(mk("r_add",    2'b10, 3'b000, 0, 0, 32'd5,        32'd7,        32'd12,       4'd3,  0, 1));
    vecs.push_back(mk("op_add",   2'b00, 3'b111, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'd3,  0, 1));
    vecs.push_back(mk("op_sub",   2'b01, 3'b000, 0, 0, 32'd3,        32'd5,        32'hFFFFFFFE, 4'd4,  0, 1));
    vecs.push_back(mk("r_sub",    2'b10, 3'b000, 1, 0, 32'd10,       32'd3,        32'd7,        4'd4,  0, 1));
    vecs.push_back(mk("i_srai",   2'b11, 3'b101, 1, 0, 32'h80000000, 32'd4,        32'hF8000000, 4'd9,  0, 1));
    vecs.push_back(mk("i_srli",   2'b11, 3'b101, 0, 0, 32'h80000000, 32'd4,        32'h08000000, 4'd8,  0, 1));
    vecs.push_back(mk("r_slt",    2'b10, 3'b010, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd1,        4'd5,  0, 1));
    vecs.push_back(mk("r_sltu",   2'b10, 3'b011, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'd6,  0, 1));
    vecs.push_back(mk("i_sltiu",  2'b11, 3'b011, 0, 0, 32'd1,        32'hFFFFFFFF, 32'd1,        4'd6,  0, 1));
    vecs.push_back(mk("r_sll",    2'b10, 3'b001, 0, 0, 32'd1,        32'h25,       32'h20,       4'd10, 0, 1));
    vecs.push_back(mk("r_srl",    2'b10, 3'b101, 0, 0, 32'h80000000, 32'd1,        32'h40000000, 4'd11, 0, 1));
    vecs.push_back(mk("r_sra",    2'b10, 3'b101, 1, 0, 32'h80000000, 32'd31,       32'hFFFFFFFF, 4'd12, 0, 1));
    vecs.push_back(mk("r_and",    2'b10, 3'b111, 0, 0, 32'hF0F0,     32'hFF00,     32'hF000,     4'd0,  0, 1));
    vecs.push_back(mk("r_or",     2'b10, 3'b110, 0, 0, 32'hF0F0,     32'h0F00,     32'hFFF0,     4'd1,  0, 1));
    vecs.push_back(mk("i_xori",   2'b11, 3'b100, 0, 0, 32'hFF,       32'h0F,       32'hF0,       4'd2,  0, 1));
    vecs.push_back(mk("i_slli",   2'b11, 3'b001, 0, 0, 32'd3,        32'd2,        32'd12,       4'd7,  0, 1));
    vecs.push_back(mk("ill_r_and",2'b10, 3'b111, 1, 0, 32'hFFFF,     32'hFFFF,     32'd0,        4'd0,  1, 1));
    vecs.push_back(mk("ill_slli", 2'b11, 3'b001, 1, 0, 32'd3,        32'd2,        32'd0,        4'd0,  1, 1));
`ifdef MDU_EN
    vecs.push_back(mk("mul",      2'b10, 3'b000, 0, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 4'd13, 0, 33));
    vecs.push_back(mk("mulh",     2'b10, 3'b001, 0, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4'd13, 0, 33));
    vecs.push_back(mk("mulhsu",   2'b10, 3'b010, 0, 1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4'd13, 0, 33));
    vecs.push_back(mk("mulhu",    2'b10, 3'b011, 0, 1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 4'd13, 0, 33));
    vecs.push_back(mk("div_by0",  2'b10, 3'b100, 0, 1, 32'd7,        32'd0,        32'hFFFFFFFF, 4'd13, 0, 33));
    vecs.push_back(mk("rem_by0",  2'b10, 3'b110, 0, 1, 32'd7,        32'd0,        32'd7,        4'd13, 0, 33));
    vecs.push_back(mk("div_ovf",  2'b10, 3'b100, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'd13, 0, 33));
    vecs.push_back(mk("rem_ovf",  2'b10, 3'b110, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'd13, 0, 33));
    vecs.push_back(mk("div_neg",  2'b10, 3'b100, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'd13, 0, 33));
    vecs.push_back(mk("rem_neg",  2'b10, 3'b110, 0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'd13, 0, 33));
    vecs.push_back(mk("divu",     2'b10, 3'b101, 0, 1, 32'd100,      32'd7,        32'd14,       4'd13, 0, 33));
    vecs.push_back(mk("remu",     2'b10, 3'b111, 0, 1, 32'd100,      32'd7,        32'd2,        4'd13, 0, 33));
    vecs.push_back(mk("ill_m_f75",2'b10, 3'b000, 1, 1, 32'd3,        32'd4,        32'd0,        4'd0,  1, 1));
`else
    vecs.push_back(mk("ill_mul",  2'b10, 3'b000, 0, 1, 32'hFFFFFFFF, 32'd2,        32'd0,        4'd0,  1, 1));
    vecs.push_back(mk("ill_div",  2'b10, 3'b100, 0, 1, 32'd7,        32'd0,        32'd0,        4'd0,  1, 1));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset result",  {32'd0, result}, 64'd0);
    chk("reset alu_sel", {60'd0, alu_sel}, 64'd0);
    chk("reset flags",   {61'd0, illegal_op, valid_out, ready_out}, 64'b001);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // consumer stall: outputs hold while ready_in is low
    drive(2'b10, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7);
    chk("stall first valid", {63'd0, valid_out}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall hold", {27'd0, valid_out, alu_sel, result}, {27'd0, 1'b1, 4'd3, 32'd12});
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    chk("stall release", {62'd0, ready_out, valid_out}, 64'b10);

    // reset mid-operation (BUSY when MDU_EN, held DONE otherwise)
    drive(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst result", {32'd0, result}, 64'd0);
    chk("midrst state", {56'd0, alu_sel, illegal_op, valid_out, ready_out, 1'b0}, 64'b0010);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_quiet("midrst no valid", 40);

    // flush mid-operation
    drive(2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush idle", {62'd0, ready_out, valid_out}, 64'b10);
    watch_quiet("flush no valid", 40);

    // flush beats a simultaneous request
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; op_a = 32'd1; op_b = 32'd1;
    valid_in = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    flush = 1'b0;
    chk("flush vs valid", {62'd0, ready_out, valid_out}, 64'b10);
    watch_quiet("flush vs valid quiet", 5);

    run_vec(vecs[vecs.size() - 1]);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
